// File: rtl/cpu_ctrl_core_if.sv
// Bus bundle between the CPU register file / control glue and cpu_ctrl_core.
// master drives opcode, operands and PC controls; slave returns ALU, PC and sequencer outputs.
interface cpu_ctrl_core_if;
    logic [7:0] opcode;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       cin;
    logic       sub;
    logic [7:0] pc_in;
    logic       pc_en;
    logic       pc_load;
    logic [7:0] alu_out;
    logic       cout;
    logic       eq_zero;
    logic [7:0] pc_out;
    logic [3:0] cycle;
    logic [3:0] state;
    logic       jump_ok;

    modport master (
        output opcode, in_a, in_b, cin, sub,
        output pc_in, pc_en, pc_load,
        input  alu_out, cout, eq_zero,
        input  pc_out, cycle, state, jump_ok
    );

    modport slave (
        input  opcode, in_a, in_b, cin, sub,
        input  pc_in, pc_en, pc_load,
        output alu_out, cout, eq_zero,
        output pc_out, cycle, state, jump_ok
    );
endinterface

// File: rtl/cpu_ctrl_core.sv
// Execution core of the 8-bit bus CPU: ALU, program counter and microcycle
// sequencer that maps (cycle, opcode) to one micro-state per clock.
// Ports: clk, reset (sync, active-high), bus (cpu_ctrl_core_if.slave):
//   in  opcode, in_a, in_b, cin, sub, pc_in, pc_en, pc_load
//   out alu_out, cout, eq_zero, pc_out, cycle, state, jump_ok
// Option: define CPU_CTRL_COND_JUMP_EN to let JEZ/JNZ test eq_zero;
//   otherwise only JMP asserts jump_ok.
module cpu_ctrl_core (
    input  logic                 clk,
    input  logic                 reset,
    cpu_ctrl_core_if.slave       bus
);

    localparam logic [7:0] OP_LDA = 8'h10;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h21;
    localparam logic [7:0] OP_STA = 8'h30;
    localparam logic [7:0] OP_OUT = 8'h40;
    localparam logic [7:0] OP_JMP = 8'h50;
    localparam logic [7:0] OP_JEZ = 8'h51;
    localparam logic [7:0] OP_JNZ = 8'h52;
    localparam logic [7:0] OP_HLT = 8'hFF;

    typedef enum logic [3:0] {
        ST_NEXT       = 4'd0,
        ST_FETCH_PC   = 4'd1,
        ST_FETCH_INST = 4'd2,
        ST_HALT       = 4'd3,
        ST_JUMP       = 4'd4,
        ST_OUT_A      = 4'd5,
        ST_RAM_A      = 4'd6,
        ST_RAM_B      = 4'd7,
        ST_ALU_OP     = 4'd8,
        ST_LOAD_ADDR  = 4'd9,
        ST_STORE_A    = 4'd10
    } state_t;

    logic [3:0] cycle;
    logic [3:0] cycle_nxt;
    state_t     state;
    logic [8:0] sum;
    logic [7:0] pc;
    logic       zero;
    logic       jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= 4'd0;
        end else begin
            cycle <= cycle_nxt;
        end
    end

    // Micro-state decode; opcode is not latched, the instruction
    // register upstream keeps it stable except during FETCH_INST.
    always_comb begin
        state     = ST_NEXT;
        cycle_nxt = cycle + 4'd1;
        if (cycle == 4'd0) begin
            state = ST_FETCH_PC;
        end else if (cycle == 4'd1) begin
            state = ST_FETCH_INST;
        end else begin
            case (bus.opcode)
                OP_LDA: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_RAM_A;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_ADD, OP_SUB: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_RAM_B;
                        4'd5:    state = ST_ALU_OP;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_STA: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_STORE_A;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_OUT: begin
                    if (cycle == 4'd2) begin
                        state = ST_OUT_A;
                    end
                end
                OP_JMP, OP_JEZ, OP_JNZ: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_JUMP;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_HLT:  state = ST_HALT;
                default: state = ST_NEXT;
            endcase
        end

        if (state == ST_NEXT) begin
            cycle_nxt = 4'd0;
        end else if (state == ST_HALT) begin
            cycle_nxt = cycle;
        end
    end

    // Subtract is a + ~b + 1, so cout is the inverted borrow.
    always_comb begin
        if (bus.sub) begin
            sum = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + 9'd1;
        end else begin
            sum = {1'b0, bus.in_a} + {1'b0, bus.in_b}
                + {8'd0, bus.cin};
        end
    end

    assign zero = (bus.in_a == 8'd0);

`ifdef CPU_CTRL_COND_JUMP_EN
    assign jump = (bus.opcode == OP_JMP)
                | ((bus.opcode == OP_JEZ) & zero)
                | ((bus.opcode == OP_JNZ) & ~zero);
`else
    assign jump = (bus.opcode == OP_JMP);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 8'd0;
        end else if (bus.pc_en) begin
            if (bus.pc_load) begin
                pc <= bus.pc_in;
            end else begin
                pc <= pc + 8'd1;
            end
        end
    end

    assign bus.alu_out = sum[7:0];
    assign bus.cout    = sum[8];
    assign bus.eq_zero = zero;
    assign bus.pc_out  = pc;
    assign bus.cycle   = cycle;
    assign bus.state   = state;
    assign bus.jump_ok = jump;

endmodule

// File: tb/tb_cpu_ctrl_core.sv
// Self-checking bench for cpu_ctrl_core: vector table for ALU/jump decode,
// directed multi-cycle sequences, and a random instruction stream vs a model.
module tb_cpu_ctrl_core;

`ifdef CPU_CTRL_COND_JUMP_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    cpu_ctrl_core_if bus_if ();

    cpu_ctrl_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] alu;
        logic       co;
        logic       z;
        logic       j_c;
        logic       j_n;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle_in();
        bus_if.in_a    = 8'd0;
        bus_if.in_b    = 8'd0;
        bus_if.cin     = 1'b0;
        bus_if.sub     = 1'b0;
        bus_if.pc_in   = 8'd0;
        bus_if.pc_en   = 1'b0;
        bus_if.pc_load = 1'b0;
    endtask

    function automatic logic exp_jump(logic [7:0] op, logic [7:0] a);
        return (op == 8'h50)
            || (COND && op == 8'h51 && a == 8'd0)
            || (COND && op == 8'h52 && a != 8'd0);
    endfunction

    // Expected micro-state list of one whole instruction.
    function automatic void seq_of(input logic [7:0] op,
                                   output int q[$]);
        case (op)
            8'h10:        q = '{1, 2, 1, 9, 6, 0};
            8'h20, 8'h21: q = '{1, 2, 1, 9, 7, 8, 0};
            8'h30:        q = '{1, 2, 1, 9, 10, 0};
            8'h40:        q = '{1, 2, 5, 0};
            8'h50, 8'h51,
            8'h52:        q = '{1, 2, 1, 4, 0};
            default:      q = '{1, 2, 0};
        endcase
    endfunction

    initial begin
        int seq[$];
        int pc_m;
        int s;
        logic [7:0] ops[10];
        logic [7:0] op;

        vecs[0]  = '{8'h00, 8'h05, 8'h03, 0, 0, 8'h08, 0, 0, 0, 0};
        vecs[1]  = '{8'h00, 8'h05, 8'h03, 0, 1, 8'h02, 1, 0, 0, 0};
        vecs[2]  = '{8'h00, 8'h03, 8'h05, 0, 1, 8'hFE, 0, 0, 0, 0};
        vecs[3]  = '{8'h00, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0, 0};
        vecs[4]  = '{8'h00, 8'h05, 8'h03, 1, 0, 8'h09, 0, 0, 0, 0};
        vecs[5]  = '{8'h00, 8'h05, 8'h03, 1, 1, 8'h02, 1, 0, 0, 0};
        vecs[6]  = '{8'h51, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0};
        vecs[7]  = '{8'h51, 8'h01, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0};
        vecs[8]  = '{8'h52, 8'h01, 8'h00, 0, 0, 8'h01, 0, 0, 1, 0};
        vecs[9]  = '{8'h52, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0};
        vecs[10] = '{8'h50, 8'h07, 8'h00, 0, 0, 8'h07, 0, 0, 1, 1};
        vecs[11] = '{8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 1, 1, 0, 0};
        vecs[12] = '{8'h00, 8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0, 0, 0};
        vecs[13] = '{8'h53, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0};

        ops = '{8'h00, 8'h10, 8'h20, 8'h21, 8'h30,
                8'h40, 8'h50, 8'h51, 8'h52, 8'h00};

        idle_in();
        bus_if.opcode = 8'h00;
        do_reset();

        // Reset state then a NOP: cycle 0,1,2,0
        chk("rst_pc", bus_if.pc_out, 0);
        chk("rst_cycle", bus_if.cycle, 0);
        chk("rst_state", bus_if.state, 1);
        tick();
        chk("nop_c1", bus_if.cycle, 1);
        chk("nop_s1", bus_if.state, 2);
        tick();
        chk("nop_c2", bus_if.cycle, 2);
        chk("nop_s2", bus_if.state, 0);
        tick();
        chk("nop_c0", bus_if.cycle, 0);
        chk("nop_s0", bus_if.state, 1);

        // Combinational vector table
        for (int i = 0; i < 14; i++) begin
            bus_if.opcode = vecs[i].op;
            bus_if.in_a   = vecs[i].a;
            bus_if.in_b   = vecs[i].b;
            bus_if.cin    = vecs[i].cin;
            bus_if.sub    = vecs[i].sub;
            #1;
            chk($sformatf("v%0d_alu", i), bus_if.alu_out, vecs[i].alu);
            chk($sformatf("v%0d_cout", i), bus_if.cout, vecs[i].co);
            chk($sformatf("v%0d_z", i), bus_if.eq_zero, vecs[i].z);
            chk($sformatf("v%0d_jmp", i), bus_if.jump_ok,
                COND ? vecs[i].j_c : vecs[i].j_n);
        end
        idle_in();
        bus_if.opcode = 8'h00;

        // PC load, increment across wrap, hold
        do_reset();
        bus_if.pc_en   = 1'b1;
        bus_if.pc_load = 1'b1;
        bus_if.pc_in   = 8'hFE;
        tick();
        chk("pc_load", bus_if.pc_out, 8'hFE);
        bus_if.pc_load = 1'b0;
        tick();
        chk("pc_inc", bus_if.pc_out, 8'hFF);
        bus_if.pc_en = 1'b0;
        tick();
        tick();
        chk("pc_hold", bus_if.pc_out, 8'hFF);
        bus_if.pc_en = 1'b1;
        tick();
        chk("pc_wrap", bus_if.pc_out, 8'h00);
        bus_if.pc_en = 1'b0;

        // ADD: 1,2,1,9,7,8,0 then next fetch
        bus_if.opcode = 8'h20;
        do_reset();
        seq = '{1, 2, 1, 9, 7, 8, 0, 1};
        foreach (seq[i]) begin
            chk($sformatf("add_s%0d", i), bus_if.state, seq[i]);
            if (i < 7) tick();
        end

        // HLT holds from cycle 2 until reset
        bus_if.opcode = 8'hFF;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("hlt_s%0d", i), bus_if.state, 3);
            chk($sformatf("hlt_c%0d", i), bus_if.cycle, 2);
            tick();
        end
        do_reset();
        chk("hlt_rst_c", bus_if.cycle, 0);
        chk("hlt_rst_s", bus_if.state, 1);

        // Reset in cycle 4 of ADD with pc_en high
        bus_if.opcode = 8'h20;
        bus_if.pc_en  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_c4", bus_if.cycle, 4);
        chk("abort_s4", bus_if.state, 7);
        chk("abort_pc4", bus_if.pc_out, 4);
        do_reset();
        chk("abort_c", bus_if.cycle, 0);
        chk("abort_pc", bus_if.pc_out, 0);
        bus_if.pc_en = 1'b0;

        // Random instruction stream against the model
        do_reset();
        pc_m = 0;
        for (int k = 0; k < 80; k++) begin
            op = ops[$urandom_range(0, 9)];
            if (k % 10 == 9) begin
                op = 8'($urandom_range(0, 254));
            end
            bus_if.opcode = op;
            seq_of(op, seq);
            foreach (seq[i]) begin
                bus_if.in_a    = ($urandom_range(0, 3) == 0)
                               ? 8'd0 : 8'($urandom);
                bus_if.in_b    = 8'($urandom);
                bus_if.cin     = 1'($urandom);
                bus_if.sub     = 1'($urandom);
                bus_if.pc_in   = 8'($urandom);
                bus_if.pc_en   = 1'($urandom);
                bus_if.pc_load = 1'($urandom);
                #1;
                if (bus_if.sub) begin
                    s = int'(bus_if.in_a) - int'(bus_if.in_b) + 256;
                end else begin
                    s = int'(bus_if.in_a) + int'(bus_if.in_b)
                      + int'(bus_if.cin);
                end
                chk("r_state", bus_if.state, seq[i]);
                chk("r_cycle", bus_if.cycle, i);
                chk("r_alu", bus_if.alu_out, s % 256);
                chk("r_cout", bus_if.cout, s / 256);
                chk("r_z", bus_if.eq_zero, bus_if.in_a == 0);
                chk("r_jmp", bus_if.jump_ok,
                    exp_jump(op, bus_if.in_a));
                chk("r_pc", bus_if.pc_out, pc_m);
                if (bus_if.pc_en) begin
                    pc_m = bus_if.pc_load ? int'(bus_if.pc_in)
                                          : (pc_m + 1) % 256;
                end
                tick();
            end
        end
        chk("r_end_cycle", bus_if.cycle, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
